axi_hp_rd_arbiter: RTL and testbench

- Shares one AXI3 HP read channel (AR + R) between NREQ burst-read requesters, e.g. DMA engines and the stream/test masters of the correlator subsystem.
- Grants AR access round-robin and issues one burst per grant.
- Keeps an in-order ownership queue of outstanding bursts and steers each returning R beat to the owning requester.
- Sits between the requester masters and the axi_hp_interface port; single clock domain.

---
 rtl/axi_hp_rd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axi_hp_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 HP read channel among NREQ burst requesters.
// Define AXI_HP_RD_ARB_PRIO_EN to give requester 0 strict priority over the others.
module axi_hp_rd_arbiter #(
    parameter int NREQ    = 4,
    parameter int D_WIDTH = 64,
    parameter int MAX_OUT = 8,
    parameter int ADDR_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*4-1:0]          req_len,
    output logic [NREQ-1:0]            req_ready,
    output logic [D_WIDTH-1:0]         rsp_data,
    output logic [NREQ-1:0]            rsp_valid,
    output logic                       rsp_last,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [ADDR_W-1:0]          m_araddr,
    output logic [3:0]                 m_arlen,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [D_WIDTH-1:0]         m_rdata,
    input  logic                       m_rvalid,
    input  logic                       m_rlast,
    output logic                       m_rready,
    output logic [$clog2(MAX_OUT):0]   outstanding
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(MAX_OUT);
    localparam int OW  = PW + 1;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      winner_q, winner_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [3:0]          arlen_q, arlen_d;
    logic [IDW-1:0]      fifo_q [MAX_OUT];
    logic [IDW-1:0]      fifo_d [MAX_OUT];
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]       outstanding_q, outstanding_d;

    logic                grant_valid;
    logic [IDW-1:0]      grant_id;
    logic                push, pop, empty;
    logic [IDW-1:0]      owner;

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
`ifdef AXI_HP_RD_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_valid = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_valid && idx != 0 && req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = IDW'(idx);
                end
            end
        end
`else
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        req_ready = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid && outstanding_q < MAX_OUT_C) begin
                    req_ready[grant_id] = 1'b1;
                    winner_d = grant_id;
                    araddr_d = req_addr[grant_id*ADDR_W +: ADDR_W];
                    arlen_d  = req_len[grant_id*4 +: 4];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    push    = 1'b1;
                    state_d = IDLE;
`ifdef AXI_HP_RD_ARB_PRIO_EN
                    if (winner_q != '0)
`endif
                    ptr_d = (winner_q == IDW'(NREQ-1)) ? '0 : winner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // R beats are steered to the FIFO head; an empty FIFO stalls the channel.
    always_comb begin
        empty     = (outstanding_q == '0);
        owner     = fifo_q[rd_q];
        rsp_valid = '0;
        m_rready  = 1'b0;
        if (!empty) begin
            rsp_valid[owner] = m_rvalid;
            m_rready         = rsp_ready[owner];
        end
        rsp_data = m_rdata;
        rsp_last = m_rlast;
        pop      = m_rvalid & m_rready & m_rlast;
    end

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        outstanding_d = outstanding_q;
        if (push) begin
            fifo_d[wr_q] = winner_q;
            wr_d = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            winner_q      <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            outstanding_q <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            outstanding_q <= outstanding_d;
            fifo_q        <= fifo_d;
        end
    end

    assign m_arvalid   = (state_q == ISSUE);
    assign m_araddr    = araddr_q;
    assign m_arlen     = arlen_q;
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_axi_hp_rd_arbiter.sv
// Directed self-checking bench for axi_hp_rd_arbiter (NREQ=4, MAX_OUT=8).
module tb_axi_hp_rd_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [15:0]  req_len;
    logic [3:0]   req_ready;
    logic [63:0]  rsp_data;
    logic [3:0]   rsp_valid;
    logic         rsp_last;
    logic [3:0]   rsp_ready;
    logic [31:0]  m_araddr;
    logic [3:0]   m_arlen;
    logic         m_arvalid;
    logic         m_arready;
    logic [63:0]  m_rdata;
    logic         m_rvalid;
    logic         m_rlast;
    logic         m_rready;
    logic [3:0]   outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    axi_hp_rd_arbiter #(.NREQ(4), .D_WIDTH(64), .MAX_OUT(8), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
        m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
        cyc; cyc;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        m_rvalid = 1'b1; rsp_ready = 4'hF;
        #1;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", m_arvalid); end
        n_checks++; if (m_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h expected 0", m_araddr); end
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (m_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready_empty: got %b expected 0", m_rready); end
        n_checks++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid_empty: got %b expected 0000", rsp_valid); end
        m_rvalid = 1'b0; rsp_ready = '0;
    endtask

    task automatic test_single;
        do_reset;
        req_addr[2*32 +: 32] = 32'h1000; req_len[2*4 +: 4] = 4'd3;
        req_valid = 4'b0100; m_arready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b expected 0100", req_ready); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_early: got %b expected 0", m_arvalid); end
        cyc;
        req_valid = '0;
        #1;
        n_checks++; if (m_arvalid !== 1'b1) begin n_fail++; $display("FAIL single_arvalid: got %b expected 1", m_arvalid); end
        n_checks++; if (m_araddr !== 32'h1000) begin n_fail++; $display("FAIL single_araddr: got %h expected 1000", m_araddr); end
        n_checks++; if (m_arlen !== 4'd3) begin n_fail++; $display("FAIL single_arlen: got %0d expected 3", m_arlen); end
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL single_out0: got %0d expected 0", outstanding); end
        cyc;
        m_arready = 1'b0;
        #1;
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %b expected 0", m_arvalid); end
        n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL single_out1: got %0d expected 1", outstanding); end
        rsp_ready = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1; m_rdata = 64'hA000 + 64'(k); m_rlast = (k == 3);
            #1;
            n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid beat %0d: got %b expected 0100", k, rsp_valid); end
            n_checks++; if (rsp_data !== 64'hA000 + 64'(k)) begin n_fail++; $display("FAIL single_rsp_data beat %0d: got %h expected %h", k, rsp_data, 64'hA000 + 64'(k)); end
            n_checks++; if (rsp_last !== (k == 3)) begin n_fail++; $display("FAIL single_rsp_last beat %0d: got %b expected %b", k, rsp_last, (k == 3)); end
            n_checks++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL single_rready beat %0d: got %b expected 1", k, m_rready); end
            n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL single_out_hold beat %0d: got %0d expected 1", k, outstanding); end
            cyc;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = '0;
        #1;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL single_out_end: got %0d expected 0", outstanding); end
    endtask

    task automatic test_fairness;
        int order [8];
        int ng;
        int exp_id;
        do_reset;
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h100 * (i + 1);
        req_valid = 4'hF; m_arready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            #1;
            if (req_ready != 4'h0) begin
                n_checks++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL fair_onehot: got %b expected one-hot", req_ready); end
                for (int j = 0; j < 4; j++) if (req_ready[j]) order[ng] = j;
                ng++;
            end
            cyc;
        end
        req_valid = '0;
        n_checks++; if (ng != 8) begin n_fail++; $display("FAIL fair_grant_count: got %0d expected 8", ng); end
        for (int g = 0; g < ng; g++) begin
`ifdef AXI_HP_RD_ARB_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            n_checks++; if (order[g] != exp_id) begin n_fail++; $display("FAIL fair_order grant %0d: got %0d expected %0d", g, order[g], exp_id); end
        end
        cyc;
        n_checks++; if (outstanding !== 4'd8) begin n_fail++; $display("FAIL fair_out_full: got %0d expected 8", outstanding); end
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; rsp_ready = 4'hF;
        for (int g = 0; g < 8; g++) begin
`ifdef AXI_HP_RD_ARB_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            #1;
            n_checks++; if (rsp_valid !== (4'b0001 << exp_id)) begin n_fail++; $display("FAIL fair_rsp_owner burst %0d: got %b expected %b", g, rsp_valid, 4'b0001 << exp_id); end
            cyc;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = '0;
        #1;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL fair_out_drained: got %0d expected 0", outstanding); end
    endtask

    task automatic test_full_queue;
        int hs;
        int ng;
        do_reset;
        req_valid = 4'hF; m_arready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (m_arvalid && m_arready) hs++;
            cyc;
        end
        #1;
        n_checks++; if (hs != 8) begin n_fail++; $display("FAIL full_handshakes: got %0d expected 8", hs); end
        n_checks++; if (outstanding !== 4'd8) begin n_fail++; $display("FAIL full_out: got %0d expected 8", outstanding); end
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL full_no_ready: got %b expected 0000", req_ready); end
        m_rvalid = 1'b1; m_rlast = 1'b1; rsp_ready = 4'hF;
        #1;
        n_checks++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL full_rready: got %b expected 1", m_rready); end
        cyc;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 4'h0) ng++;
            cyc;
        end
        n_checks++; if (ng != 1) begin n_fail++; $display("FAIL full_regrant: got %0d expected 1", ng); end
        n_checks++; if (outstanding !== 4'd8) begin n_fail++; $display("FAIL full_out_refill: got %0d expected 8", outstanding); end
        req_valid = '0; rsp_ready = '0;
    endtask

    task automatic test_backpressure;
        int  k;
        bit  tog;
        do_reset;
        req_addr[1*32 +: 32] = 32'h2000; req_len[1*4 +: 4] = 4'd15;
        req_valid = 4'b0010; m_arready = 1'b1;
        cyc;
        req_valid = '0;
        cyc;
        m_arready = 1'b0;
        #1;
        n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL bp_out_start: got %0d expected 1", outstanding); end
        k = 0; tog = 1'b1;
        for (int c = 0; c < 40 && k < 16; c++) begin
            m_rvalid = 1'b1; m_rdata = 64'hB00 + 64'(k); m_rlast = (k == 15);
            rsp_ready = tog ? 4'b0010 : 4'b0000;
            #1;
            n_checks++; if (m_rready !== tog) begin n_fail++; $display("FAIL bp_rready cycle %0d: got %b expected %b", c, m_rready, tog); end
            n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp_valid cycle %0d: got %b expected 0010", c, rsp_valid); end
            n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL bp_no_early_pop beat %0d: got %0d expected 1", k, outstanding); end
            if (tog) k++;
            tog = !tog;
            cyc;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = '0;
        #1;
        n_checks++; if (k != 16) begin n_fail++; $display("FAIL bp_beats: got %0d expected 16", k); end
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL bp_pop_last: got %0d expected 0", outstanding); end
    endtask

    task automatic test_ar_stall;
        do_reset;
        req_addr[1*32 +: 32] = 32'h3000; req_len[1*4 +: 4] = 4'd5;
        req_addr[2*32 +: 32] = 32'h4000; req_len[2*4 +: 4] = 4'd2;
        req_valid = 4'b0110; m_arready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_first_grant: got %b expected 0010", req_ready); end
        cyc;
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if (m_arvalid !== 1'b1) begin n_fail++; $display("FAIL stall_arvalid cycle %0d: got %b expected 1", c, m_arvalid); end
            n_checks++; if (m_araddr !== 32'h3000) begin n_fail++; $display("FAIL stall_araddr cycle %0d: got %h expected 3000", c, m_araddr); end
            n_checks++; if (m_arlen !== 4'd5) begin n_fail++; $display("FAIL stall_arlen cycle %0d: got %0d expected 5", c, m_arlen); end
            n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL stall_no_ready cycle %0d: got %b expected 0000", c, req_ready); end
            cyc;
        end
        m_arready = 1'b1;
        cyc;
        #1;
        n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL stall_out: got %0d expected 1", outstanding); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_next_grant: got %b expected 0100", req_ready); end
        cyc;
        req_valid = '0;
        #1;
        n_checks++; if (m_araddr !== 32'h4000) begin n_fail++; $display("FAIL stall_second_addr: got %h expected 4000", m_araddr); end
        n_checks++; if (m_arlen !== 4'd2) begin n_fail++; $display("FAIL stall_second_len: got %0d expected 2", m_arlen); end
        cyc;
        m_arready = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_valid = 4'b0001; m_arready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (outstanding == 4'd3) break;
            cyc;
        end
        n_checks++; if (outstanding !== 4'd3) begin n_fail++; $display("FAIL mid_reach3: got %0d expected 3", outstanding); end
        cyc;
        reset = 1'b1; m_rvalid = 1'b1; rsp_ready = 4'hF;
        cyc;
        reset = 1'b0; req_valid = '0;
        #1;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL mid_out: got %0d expected 0", outstanding); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_arvalid: got %b expected 0", m_arvalid); end
        n_checks++; if (m_rready !== 1'b0) begin n_fail++; $display("FAIL mid_rready: got %b expected 0", m_rready); end
        n_checks++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b expected 0000", rsp_valid); end
        m_rvalid = 1'b0; rsp_ready = '0; m_arready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_full_queue;
        test_backpressure;
        test_ar_stall;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
